// File: rtl/uart_frame_arb.sv
// ============================================================================
// Module   : uart_frame_arb
// Purpose  : Round-robin arbiter that shares one UART byte transmitter
//            between NREQ telemetry requesters. Each grant sends one frame:
//            SYNC, ID, 8 msg bytes (MSB first) and an optional XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_arb #(
    parameter int         NREQ   = 4,
    parameter logic [7:0] SYNC   = 8'hA5,
    parameter bit         CHK_EN = 1'b1
) (
    input  logic                 clk_50m,
    input  logic                 sys_rstn,
    input  logic                 en,
    input  logic [NREQ-1:0]      u_req,
    output logic [NREQ-1:0]      u_ack,
    input  logic [NREQ*64-1:0]   u_msg,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_ID   = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [NREQ-1:0] armed;
    logic [63:0]     msg;
    logic [2:0]      cur_ch;
    logic [3:0]      seq;
    logic [2:0]      byte_idx;

    logic [NREQ-1:0] elig;
    logic            grant_any;
    logic [GW-1:0]   grant_idx;
    logic [GW:0]     scan_sum;
    logic [7:0]      id_byte;
    logic [7:0]      chk_byte;
    logic [7:0]      data_nxt;
    logic            accept;

    assign elig     = u_req & armed;
    assign accept   = tx_valid && tx_ready;
    assign id_byte  = {seq, 1'b0, cur_ch};
    // Byte k sits at bit offset 8*(7-k); for 3-bit k, 7-k is simply ~k.
    assign data_nxt = msg[{~(byte_idx + 3'd1), 3'b000} +: 8];

    // Scan from farthest to nearest so the nearest eligible channel after
    // last_grant is the one that survives.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        scan_sum  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            scan_sum = {1'b0, last_grant} + (GW+1)'(i);
            if (scan_sum >= (GW+1)'(NREQ))
                scan_sum = scan_sum - (GW+1)'(NREQ);
            if (elig[scan_sum[GW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        chk_byte = id_byte;
        for (int k = 0; k < 8; k++)
            chk_byte = chk_byte ^ msg[8*k +: 8];
    end

    always_ff @(posedge clk_50m or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= S_IDLE;
            u_ack      <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= 16'h0000;
            seq        <= 4'h0;
            last_grant <= GW'(NREQ-1);
            armed      <= '1;
            msg        <= 64'h0;
            cur_ch     <= 3'd0;
            byte_idx   <= 3'd0;
        end else begin
            u_ack <= '0;
            // A channel re-arms only after it has been seen low.
            armed <= armed | ~u_req;
            case (state)
                S_IDLE: begin
                    if (en && grant_any) begin
                        msg               <= u_msg[64*grant_idx +: 64];
                        last_grant        <= grant_idx;
                        cur_ch            <= 3'(grant_idx);
                        u_ack             <= NREQ'(1) << grant_idx;
                        armed[grant_idx]  <= 1'b0;
                        tx_data           <= SYNC;
                        tx_valid          <= 1'b1;
                        busy              <= 1'b1;
                        state             <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (accept) begin
                        tx_data <= id_byte;
                        state   <= S_ID;
                    end
                end
                S_ID: begin
                    if (accept) begin
                        tx_data  <= msg[63:56];
                        byte_idx <= 3'd0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (byte_idx == 3'd7) begin
                            if (CHK_EN) begin
                                tx_data <= chk_byte;
                                state   <= S_CHK;
                            end else begin
                                tx_valid  <= 1'b0;
                                busy      <= 1'b0;
                                frame_cnt <= frame_cnt + 16'd1;
                                seq       <= seq + 4'd1;
                                state     <= S_IDLE;
                            end
                        end else begin
                            tx_data  <= data_nxt;
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        tx_valid  <= 1'b0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        seq       <= seq + 4'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
